// File: rtl/uart_rx_param_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_param_pkg
//   Shared definitions for the parametrised UART receiver.
//   - uart_rx_state_t : receiver FSM state encoding (also exported for debug)
//   - UART_BAUD_DIV_DEFAULT : clk cycles per bit for 50 MHz / 115200 baud
// -----------------------------------------------------------------------------
package uart_rx_param_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_rx_state_t;

  localparam int UART_BAUD_DIV_DEFAULT = 434;

endpackage

// File: rtl/uart_rx_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_rx_baud_cnt
//   Free-running bit-period counter with synchronous clear. Counts
//   0..BAUD_DIV-1 and wraps, so a state that stays put sees full_tick once
//   per bit period.
// Ports
//   clk        in  system clock
//   rst        in  synchronous, active-high reset
//   clr        in  restart the period at 0 on the next edge
//   half_tick  out count is at the last cycle of the first half period
//   full_tick  out count is at the last cycle of the full period
// -----------------------------------------------------------------------------
module uart_rx_baud_cnt
  import uart_rx_param_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic half_tick,
  output logic full_tick
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  assign half_tick = (cnt == HALF_LAST);
  assign full_tick = (cnt == FULL_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (full_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
//   Parametrised UART receiver: 2-FF synchroniser, start-bit glitch rejection,
//   LSB-first shift register, optional parity check, frame/overrun reporting
//   and a valid/ready output holding register.
//   Optional feature macro: UART_RX_PARITY_EN (adds the parity bit / PARITY
//   state; when undefined parity_err is tied to 0).
// Parameters
//   DATA_W (5..16), BAUD_DIV (>=4), STOP_BITS (1 or 2), PARITY_ODD (0 even / 1 odd)
// Ports
//   clk, rst       clock, synchronous active-high reset
//   rx             asynchronous serial line, idle high
//   rx_data        received word, held until accepted
//   rx_valid       rx_data and flags valid
//   rx_ready       consumer accepts when rx_valid && rx_ready
//   frame_err      a sampled stop bit was 0 (qualified by rx_valid)
//   parity_err     parity mismatch (qualified by rx_valid)
//   overrun        >=1 frame dropped while the held word was pending
//   dbg_state      current receiver FSM state
// Handshake: rx_valid/rx_data/flags are stable from the cycle rx_valid rises
//   until the edge where rx_valid && rx_ready; rx_valid drops the next cycle
//   unless a new frame completes on that same edge, in which case the new word
//   is loaded and rx_valid stays high. The receiver never waits for rx_ready.
// -----------------------------------------------------------------------------
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BAUD_DIV   = UART_BAUD_DIV_DEFAULT,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output uart_rx_state_t    dbg_state
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_rx_state_t    state, state_next;
  logic              rx_meta, rx_s, rx_s_d;
  logic [1:0]        sync_fill;
  logic              armed;
  logic              start_edge;
  logic              half_tick, full_tick, baud_clr;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              ferr_acc;
  logic              done, done_ferr, accept, load;

  // Synchroniser. sync_fill marks when rx_s carries the real line rather
  // than its reset value; armed is only set once the real line is seen high,
  // so a line held low through reset cannot produce a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_s_d    <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      rx_s_d    <= rx_s;
      sync_fill <= {sync_fill[0], 1'b1};
      armed     <= armed | (sync_fill[1] & rx_s);
    end
  end

  assign start_edge = armed & rx_s_d & ~rx_s;

  uart_rx_baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk       (clk),
    .rst       (rst),
    .clr       (baud_clr),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE:      if (start_edge) state_next = START;
      START:     if (half_tick) state_next = rx_s ? IDLE : DATA;
      DATA: begin
        if (full_tick && bit_cnt == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY:    if (full_tick) state_next = STOP;
`endif
      STOP: begin
        if (full_tick && bit_cnt == LAST_STOP) begin
          done       = 1'b1;
          state_next = (ferr_acc | ~rx_s) ? WAIT_IDLE : IDLE;
        end
      end
      WAIT_IDLE: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    // Every state entry starts a fresh bit period.
    baud_clr = (state_next != state);
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      shift    <= '0;
      ferr_acc <= 1'b0;
    end else begin
      if (baud_clr) begin
        bit_cnt <= '0;
      end else if (full_tick && (state == DATA || state == STOP)) begin
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (state == DATA && full_tick) begin
        shift <= {rx_s, shift[DATA_W-1:1]};
      end
      if (state == IDLE) begin
        ferr_acc <= 1'b0;
      end else if (state == STOP && full_tick && !rx_s) begin
        ferr_acc <= 1'b1;
      end
    end
  end

  assign done_ferr = ferr_acc | ~rx_s;
  assign accept    = rx_valid & rx_ready;
  // A completing frame is taken only if the holding register is free or is
  // being emptied on this very edge; otherwise it is dropped.
  assign load      = done & (~rx_valid | accept);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (load) begin
      rx_data   <= shift;
      rx_valid  <= 1'b1;
      frame_err <= done_ferr;
      overrun   <= 1'b0;
    end else if (done) begin
      overrun   <= 1'b1;
    end else if (accept) begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic perr_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_acc <= 1'b0;
    end else if (state == IDLE) begin
      perr_acc <= 1'b0;
    end else if (state == PARITY && full_tick) begin
      // Expected parity bit is XOR(data) ^ PAR_ODD; any difference is an error.
      perr_acc <= rx_s ^ (^shift) ^ PAR_ODD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         parity_err <= 1'b0;
    else if (load)   parity_err <= perr_acc;
    else if (accept) parity_err <= 1'b0;
  end
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = ^PARITY_ODD;
  assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
//   Directed bench for uart_rx_param. Two instances share clk/rst:
//   dut (DATA_W=8, STOP_BITS=1) and dut5 (DATA_W=5, STOP_BITS=2), BAUD_DIV=16.
//   Build with or without UART_RX_PARITY_EN; frames follow the same macro.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;
  import uart_rx_param_pkg::*;

  localparam int BAUD    = 16;
  localparam int PAR_ODD = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic rx_ready = 1'b1;
  logic rx5 = 1'b1;
  logic rx5_ready = 1'b1;

  logic [7:0]     rx_data;
  logic           rx_valid, frame_err, parity_err, overrun;
  uart_rx_state_t dbg_state;
  logic [4:0]     rx5_data;
  logic           rx5_valid, frame5_err, parity5_err, overrun5;
  uart_rx_state_t dbg5_state;

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_W(8), .BAUD_DIV(BAUD), .STOP_BITS(1), .PARITY_ODD(PAR_ODD)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  uart_rx_param #(.DATA_W(5), .BAUD_DIV(BAUD), .STOP_BITS(2), .PARITY_ODD(PAR_ODD)) dut5 (
    .clk(clk), .rst(rst), .rx(rx5), .rx_data(rx5_data), .rx_valid(rx5_valid),
    .rx_ready(rx5_ready), .frame_err(frame5_err), .parity_err(parity5_err),
    .overrun(overrun5), .dbg_state(dbg5_state)
  );

  // Scoreboard: each entry is {parity_err, frame_err, data[15:0]}.
  logic [17:0] exp_q[$];
  logic [17:0] exp5_q[$];
  logic [17:0] cmp_e, cmp_e5;
  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int acc5_cnt = 0;
  logic [15:0] last_data, last5_data;
  logic        last_ferr, last_perr, last5_ferr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input bit sel, input logic b);
    if (sel) rx5 = b;
    else     rx  = b;
    repeat (BAUD) tick();
  endtask

  function automatic logic good_par(input logic [15:0] d);
    return (^d) ^ (PAR_ODD != 0);
  endfunction

  // Sends one frame on the selected line; stop_pat[i] is the i-th stop bit.
  // When push is set the frame must be delivered, with the flags the line
  // format implies.
  task automatic send_frame(input bit sel, input logic [15:0] d, input logic [1:0] stop_pat,
                            input logic par_bit, input bit push);
    int nb;
    int ns;
    logic [15:0] dm;
    logic fe;
    logic pe;
    nb = sel ? 5 : 8;
    ns = sel ? 2 : 1;
    dm = d & ((16'h1 << nb) - 16'h1);
    fe = 1'b0;
    for (int i = 0; i < ns; i++) if (!stop_pat[i]) fe = 1'b1;
    pe = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe = (par_bit != good_par(dm));
`endif
    if (push) begin
      if (sel) exp5_q.push_back({pe, fe, dm});
      else     exp_q.push_back({pe, fe, dm});
    end
    drive(sel, 1'b0);
    for (int i = 0; i < nb; i++) drive(sel, dm[i]);
`ifdef UART_RX_PARITY_EN
    drive(sel, par_bit);
`endif
    for (int i = 0; i < ns; i++) drive(sel, stop_pat[i]);
  endtask

  // Compare process: whenever an instance presents a word, it must match the
  // oldest undelivered frame; acceptance retires that frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          check("valid_without_frame", 32'(rx_valid), 32'd0);
        end else begin
          cmp_e = exp_q[0];
          check("rx_data", 32'(rx_data), 32'(cmp_e[15:0]));
          check("frame_err", 32'(frame_err), 32'(cmp_e[16]));
          check("parity_err", 32'(parity_err), 32'(cmp_e[17]));
          if (rx_ready) begin
            last_data = 16'(rx_data);
            last_ferr = frame_err;
            last_perr = parity_err;
            acc_cnt++;
            void'(exp_q.pop_front());
          end
        end
      end
      if (rx5_valid) begin
        if (exp5_q.size() == 0) begin
          check("valid5_without_frame", 32'(rx5_valid), 32'd0);
        end else begin
          cmp_e5 = exp5_q[0];
          check("rx5_data", 32'(rx5_data), 32'(cmp_e5[15:0]));
          check("frame5_err", 32'(frame5_err), 32'(cmp_e5[16]));
          check("parity5_err", 32'(parity5_err), 32'(cmp_e5[17]));
          if (rx5_ready) begin
            last5_data = 16'(rx5_data);
            last5_ferr = frame5_err;
            acc5_cnt++;
            void'(exp5_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : main
    int c;
    logic [7:0] pat [4];
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h80; pat[3] = 8'h6B;

    // Reset state
    idle(4);
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_data", 32'(rx_data), 32'd0);
    check("reset_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    idle(8);

    // Clean 0xA5 frame
    c = acc_cnt;
    send_frame(0, 16'hA5, 2'b11, good_par(16'hA5), 1);
    idle(8);
    check("a5_count", 32'(acc_cnt), 32'(c + 1));
    check("a5_data", 32'(last_data), 32'h00A5);
    check("a5_flags", {30'd0, last_perr, last_ferr}, 32'd0);

    // A few more data patterns, back to back
    for (int i = 0; i < 4; i++) send_frame(0, 16'(pat[i]), 2'b11, good_par(16'(pat[i])), 1);
    idle(8);

    // Start glitch: 5 cycles low
    c = acc_cnt;
    rx = 1'b0;
    idle(5);
    check("glitch_start", 32'(dbg_state), 32'(START));
    rx = 1'b1;
    idle(20);
    check("glitch_idle", 32'(dbg_state), 32'(IDLE));
    check("glitch_count", 32'(acc_cnt), 32'(c));

    // Stop bit 0 then a 40-cycle break
    c = acc_cnt;
    send_frame(0, 16'h3C, 2'b00, good_par(16'h3C), 1);
    idle(40);
    check("break_state", 32'(dbg_state), 32'(WAIT_IDLE));
    check("ferr_data", 32'(last_data), 32'h003C);
    check("ferr_flag", 32'(last_ferr), 32'd1);
    check("ferr_count", 32'(acc_cnt), 32'(c + 1));
    rx = 1'b1;
    idle(5);
    check("break_release", 32'(dbg_state), 32'(IDLE));
    send_frame(0, 16'h81, 2'b11, good_par(16'h81), 1);
    idle(8);
    check("after_break_data", 32'(last_data), 32'h0081);

    // Overrun: consumer stalled across two frames
    c = acc_cnt;
    rx_ready = 1'b0;
    send_frame(0, 16'h11, 2'b11, good_par(16'h11), 1);
    idle(4);
    check("ovr_first_valid", 32'(rx_valid), 32'd1);
    check("ovr_first_flag", 32'(overrun), 32'd0);
    send_frame(0, 16'h22, 2'b11, good_par(16'h22), 0);
    idle(4);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_held_data", 32'(rx_data), 32'h0011);
    rx_ready = 1'b1;
    tick();
    check("ovr_accept_valid", 32'(rx_valid), 32'd0);
    check("ovr_accept_flag", 32'(overrun), 32'd0);
    check("ovr_count", 32'(acc_cnt), 32'(c + 1));
    idle(4);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1, so 0 is an error
    send_frame(0, 16'h07, 2'b11, 1'b0, 1);
    idle(8);
    check("par_bad_flag", 32'(last_perr), 32'd1);
    check("par_bad_data", 32'(last_data), 32'h0007);
    send_frame(0, 16'h07, 2'b11, 1'b1, 1);
    idle(8);
    check("par_good_flag", 32'(last_perr), 32'd0);
`endif

    // Reset in the middle of the data bits of 0xFF
    rx = 1'b0;
    idle(BAUD);
    rx = 1'b1;
    idle(3 * BAUD);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_data", 32'(rx_data), 32'd0);
    check("rst_mid_valid", 32'(rx_valid), 32'd0);
    check("rst_mid_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    idle(8 * BAUD);
    c = acc_cnt;
    send_frame(0, 16'h5A, 2'b11, good_par(16'h5A), 1);
    idle(8);
    check("post_rst_data", 32'(last_data), 32'h005A);
    check("post_rst_count", 32'(acc_cnt), 32'(c + 1));

    // 5-bit / 2-stop instance
    c = acc5_cnt;
    send_frame(1, 16'h15, 2'b11, good_par(16'h15), 1);
    idle(8);
    check("w5_data", 32'(last5_data), 32'h0015);
    check("w5_count", 32'(acc5_cnt), 32'(c + 1));
    send_frame(1, 16'h0A, 2'b01, good_par(16'h0A), 1);
    idle(4);
    check("w5_second_stop_ferr", 32'(last5_ferr), 32'd1);
    rx5 = 1'b1;
    idle(8);
    send_frame(1, 16'h1E, 2'b10, good_par(16'h1E), 1);
    idle(8);
    check("w5_first_stop_ferr", 32'(last5_ferr), 32'd1);

    // Line held low through reset must not start a frame
    c = acc_cnt;
    rx = 1'b0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(40);
    check("low_rst_state", 32'(dbg_state), 32'(IDLE));
    rx = 1'b1;
    idle(10);
    check("low_rst_count", 32'(acc_cnt), 32'(c));
    send_frame(0, 16'hC3, 2'b11, good_par(16'hC3), 1);
    idle(8);
    check("low_rst_next_data", 32'(last_data), 32'h00C3);

    idle(4);
    check("all_delivered", 32'(exp_q.size()), 32'd0);
    check("all5_delivered", 32'(exp5_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
